// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request classification helpers for the
// load/store requester.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        LD_LO,
        LD_HI,
        ST_BYTE,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths only exist for loads.
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lsb);
        case (f3)
            F3_H, F3_HU: return (lsb[0] == 1'b0);
            F3_W:        return (lsb == 2'b00);
            default:     return 1'b1;
        endcase
    endfunction

    // Index of the final byte of a split store (halfword or word).
    function automatic logic [1:0] last_byte(input logic [2:0] f3);
        return (f3 == F3_W) ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/lsu_mem_requester_if.sv
// Request, response and data-memory port bundle of the load/store requester.
// slave: requester side; master: core plus memory side.
interface lsu_mem_requester_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_mask;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en
    );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load aligner: merges two consecutive memory words, shifts the
// addressed bytes down and applies halfword sign/zero extension.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  ofs,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [63:0] merged;
    logic [31:0] word;

    // Select the addressed bytes from {hi,lo} and extend to 32 bits
    always_comb begin
        merged = {hi, lo};
        word   = merged[{1'b0, ofs, 3'b000} +: 32];
        case (funct3)
            F3_H:    data = {{16{word[15]}}, word[15:0]};
            F3_HU:   data = {16'h0000, word[15:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_requester.sv
// Load/store requester between the memory stage and a word-addressed data
// memory. Build option: LSU_MISALIGN_SPLIT_EN splits misaligned accesses into
// aligned reads / byte writes; without it misaligned requests return an error.
module lsu_mem_requester
    import lsu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    lsu_mem_requester_if.slave bus
);

    lsu_state_t  state;
    logic        we_q;

    logic [31:0] align_hi;
    logic [31:0] align_lo;
    logic [1:0]  align_ofs;
    logic [2:0]  align_f3;
    logic [31:0] align_data;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic [2:0]  f3_q;
    logic [1:0]  k;
    logic [1:0]  k_next;

    assign k_next = k + 2'd1;
`endif

    // Aligned loads pass memory data straight through; split loads merge words
    always_comb begin
        align_hi  = '0;
        align_lo  = bus.mem_rdata;
        align_ofs = 2'b00;
        align_f3  = F3_W;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state == LD_HI) begin
            align_hi  = bus.mem_rdata;
            align_lo  = lo_q;
            align_ofs = addr_q[1:0];
            align_f3  = f3_q;
        end
`endif
    end

    lsu_load_align u_align (
        .hi     (align_hi),
        .lo     (align_lo),
        .ofs    (align_ofs),
        .funct3 (align_f3),
        .data   (align_data)
    );

    // Request FSM with registered handshake, response and memory-port outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_mask  <= '0;
            bus.mem_wr_en <= 1'b0;
            bus.mem_rd_en <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            addr_q        <= '0;
            wdata_q       <= '0;
            lo_q          <= '0;
            f3_q          <= '0;
            k             <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q          <= bus.req_we;
                        bus.req_ready <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        f3_q          <= bus.req_funct3;
                        k             <= '0;
`endif
                        if (!is_legal(bus.req_we, bus.req_funct3)) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end else if (is_aligned(bus.req_funct3, bus.req_addr[1:0])) begin
                            state         <= ACCESS;
                            bus.mem_addr  <= bus.req_addr;
                            bus.mem_mask  <= bus.req_funct3;
                            bus.mem_wdata <= bus.req_we ? bus.req_wdata : '0;
                            bus.mem_wr_en <= bus.req_we;
                            bus.mem_rd_en <= !bus.req_we;
                        end
`ifdef LSU_MISALIGN_SPLIT_EN
                        else if (bus.req_we) begin
                            state         <= ST_BYTE;
                            bus.mem_addr  <= bus.req_addr;
                            bus.mem_wdata <= bus.req_wdata;
                            bus.mem_mask  <= F3_B;
                            bus.mem_wr_en <= 1'b1;
                        end else begin
                            state         <= LD_LO;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_mask  <= F3_W;
                            bus.mem_rd_en <= 1'b1;
                        end
`else
                        else begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end
`endif
                    end
                end

                ACCESS: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= we_q ? '0 : align_data;
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= '0;
                    bus.mem_mask  <= '0;
                    bus.mem_wr_en <= 1'b0;
                    bus.mem_rd_en <= 1'b0;
                end

`ifdef LSU_MISALIGN_SPLIT_EN
                LD_LO: begin
                    state        <= LD_HI;
                    lo_q         <= bus.mem_rdata;
                    bus.mem_addr <= bus.mem_addr + 32'd4;
                end

                LD_HI: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= align_data;
                    bus.mem_addr  <= '0;
                    bus.mem_mask  <= '0;
                    bus.mem_rd_en <= 1'b0;
                end

                ST_BYTE: begin
                    if (k == last_byte(f3_q)) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        bus.mem_mask  <= '0;
                        bus.mem_wr_en <= 1'b0;
                    end else begin
                        k             <= k_next;
                        bus.mem_addr  <= addr_q + {30'd0, k_next};
                        bus.mem_wdata <= wdata_q >> {k_next, 3'b000};
                    end
                end
`endif

                RESP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                    bus.req_ready <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_requester.sv
// Directed bench for lsu_mem_requester with a byte-array data memory model.
// Expectations follow the LSU_MISALIGN_SPLIT_EN setting of the build.
module tb_lsu_mem_requester;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    lsu_mem_requester_if bus();

    lsu_mem_requester dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- data memory model ----------------
    logic [7:0] mem_b [0:63];
    logic       mem_init;
    logic [5:0] ma;
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        ma = bus.mem_addr[5:0];
        b0 = mem_b[ma];
        b1 = mem_b[ma + 6'd1];
        b2 = mem_b[ma + 6'd2];
        b3 = mem_b[ma + 6'd3];
        case (bus.mem_mask)
            F3_B:    bus.mem_rdata = {{24{b0[7]}}, b0};
            F3_BU:   bus.mem_rdata = {24'h0, b0};
            F3_H:    bus.mem_rdata = {{16{b1[7]}}, b1, b0};
            F3_HU:   bus.mem_rdata = {16'h0, b1, b0};
            default: bus.mem_rdata = {b3, b2, b1, b0};
        endcase
    end

    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= 8'h00;
            mem_b[0]  <= 8'h55; mem_b[1] <= 8'h66; mem_b[2] <= 8'h77; mem_b[3] <= 8'h88;
            mem_b[4]  <= 8'h11; mem_b[5] <= 8'h22; mem_b[6] <= 8'h33; mem_b[7] <= 8'h44;
            mem_b[62] <= 8'hF0; mem_b[63] <= 8'hE1;
        end else if (bus.mem_wr_en) begin
            mem_b[ma] <= bus.mem_wdata[7:0];
            if (bus.mem_mask != F3_B) mem_b[ma + 6'd1] <= bus.mem_wdata[15:8];
            if (bus.mem_mask == F3_W) begin
                mem_b[ma + 6'd2] <= bus.mem_wdata[23:16];
                mem_b[ma + 6'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    int both_cnt = 0;
    always @(negedge clk) if (bus.mem_rd_en && bus.mem_wr_en) both_cnt++;

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- transaction driver ----------------
    int          got_lat;
    logic [31:0] got_data;
    logic        got_err;
    int          rd_n, wr_n;
    logic [31:0] rd_log [0:7];
    logic [31:0] wr_log [0:7];
    logic [31:0] wd_log [0:7];
    logic        pulse_after, ready_after;

    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        got_lat  = 0;
        got_data = '0;
        got_err  = 1'b0;
        rd_n     = 0;
        wr_n     = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (bus.mem_rd_en) begin
                if (rd_n < 8) rd_log[rd_n] = bus.mem_addr;
                rd_n++;
            end
            if (bus.mem_wr_en) begin
                if (wr_n < 8) begin
                    wr_log[wr_n] = bus.mem_addr;
                    wd_log[wr_n] = bus.mem_wdata;
                end
                wr_n++;
            end
            if (bus.rsp_valid) begin
                got_lat  = cyc;
                got_data = bus.rsp_rdata;
                got_err  = bus.rsp_err;
                break;
            end
        end
        @(negedge clk);
        pulse_after = bus.rsp_valid;
        ready_after = bus.req_ready;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] exp_data,
                             input logic exp_err, input int exp_lat);
        check_eq({tag, "_data"}, got_data, exp_data);
        check_eq({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
        check_eq({tag, "_lat"}, got_lat, exp_lat);
    endtask

    task automatic mem_reload();
        @(negedge clk);
        #1 mem_init = 1'b1;
        @(negedge clk);
        #1 mem_init = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        mem_init       = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (2) @(negedge clk);
        #1 mem_init = 1'b0;

        check_eq("rst_req_ready", bus.req_ready, 1);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 0);
        check_eq("rst_rsp_err", bus.rsp_err, 0);
        check_eq("rst_mem_en", {bus.mem_rd_en, bus.mem_wr_en}, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 0);
        check_eq("rst_mem_mask", bus.mem_mask, 0);
        @(negedge clk);
        reset = 1'b0;

        // Aligned loads
        run_req(1'b0, F3_W, 32'h4, '0);
        check_rsp("lw4", 32'h44332211, 1'b0, 2);
        check_eq("lw4_rd_n", rd_n, 1);
        check_eq("lw4_rd_addr", rd_log[0], 32'h4);
        check_eq("lw4_wr_n", wr_n, 0);
        check_eq("lw4_pulse_len", pulse_after, 0);
        check_eq("lw4_ready_after", ready_after, 1);

        run_req(1'b0, F3_B, 32'h3, '0);
        check_rsp("lb3", 32'hFFFFFF88, 1'b0, 2);
        run_req(1'b0, F3_BU, 32'h3, '0);
        check_rsp("lbu3", 32'h00000088, 1'b0, 2);
        run_req(1'b0, F3_H, 32'h6, '0);
        check_rsp("lh6", 32'h00004433, 1'b0, 2);

        // Illegal encodings
        run_req(1'b0, 3'b011, 32'h0, '0);
        check_rsp("ld_f3_011", 32'h0, 1'b1, 1);
        check_eq("ld_f3_011_mem", rd_n + wr_n, 0);
        run_req(1'b1, F3_BU, 32'h8, 32'h000000FF);
        check_rsp("st_f3_100", 32'h0, 1'b1, 1);
        check_eq("st_f3_100_wr_n", wr_n, 0);

        // Aligned byte store then read back
        run_req(1'b1, F3_B, 32'h8, 32'h1234565A);
        check_rsp("sb8", 32'h0, 1'b0, 2);
        check_eq("sb8_wr_n", wr_n, 1);
        check_eq("sb8_wr_addr", wr_log[0], 32'h8);
        check_eq("sb8_wdata", wd_log[0], 32'h1234565A);
        check_eq("sb8_rd_n", rd_n, 0);
        run_req(1'b0, F3_W, 32'h8, '0);
        check_rsp("lw8", 32'h0000005A, 1'b0, 2);

`ifdef LSU_MISALIGN_SPLIT_EN
        run_req(1'b0, F3_H, 32'h3, '0);
        check_rsp("lh3", 32'h00001188, 1'b0, 3);
        check_eq("lh3_rd_n", rd_n, 2);
        check_eq("lh3_rd_lo", rd_log[0], 32'h0);
        check_eq("lh3_rd_hi", rd_log[1], 32'h4);
        run_req(1'b0, F3_W, 32'h2, '0);
        check_rsp("lw2", 32'h22118877, 1'b0, 3);
        run_req(1'b0, F3_W, 32'hFFFFFFFE, '0);
        check_rsp("lw_wrap", 32'h6655E1F0, 1'b0, 3);
        check_eq("lw_wrap_rd_lo", rd_log[0], 32'hFFFFFFFC);
        check_eq("lw_wrap_rd_hi", rd_log[1], 32'h0);

        run_req(1'b1, F3_W, 32'h1, 32'hAABBCCDD);
        check_rsp("sw1", 32'h0, 1'b0, 5);
        check_eq("sw1_wr_n", wr_n, 4);
        check_eq("sw1_rd_n", rd_n, 0);
        check_eq("sw1_a0", wr_log[0], 32'h1);
        check_eq("sw1_a1", wr_log[1], 32'h2);
        check_eq("sw1_a2", wr_log[2], 32'h3);
        check_eq("sw1_a3", wr_log[3], 32'h4);
        check_eq("sw1_d0", wd_log[0], 32'hAABBCCDD);
        check_eq("sw1_d1", wd_log[1], 32'h00AABBCC);
        check_eq("sw1_d2", wd_log[2], 32'h0000AABB);
        check_eq("sw1_d3", wd_log[3], 32'h000000AA);
        run_req(1'b0, F3_W, 32'h0, '0);
        check_rsp("sw1_word0", 32'hBBCCDD55, 1'b0, 2);
        run_req(1'b0, F3_W, 32'h4, '0);
        check_rsp("sw1_word4", 32'h443322AA, 1'b0, 2);
        run_req(1'b0, F3_H, 32'h1, '0);
        check_rsp("lh1", 32'hFFFFCCDD, 1'b0, 3);
        run_req(1'b0, F3_HU, 32'h1, '0);
        check_rsp("lhu1", 32'h0000CCDD, 1'b0, 3);

        // Reset in the middle of a split store, after two bytes
        mem_reload();
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h1;
        bus.req_wdata  = 32'hAABBCCDD;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check_eq("abort_wr_before", bus.mem_wr_en, 1);
        reset = 1'b1;
        #1 check_eq("abort_wr_en", bus.mem_wr_en, 0);
        check_eq("abort_mem_addr", bus.mem_addr, 0);
        check_eq("abort_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 check_eq("abort_req_ready", bus.req_ready, 1);
        run_req(1'b0, F3_W, 32'h0, '0);
        check_rsp("abort_word0", 32'h88CCDD55, 1'b0, 2);
        run_req(1'b0, F3_W, 32'h4, '0);
        check_rsp("abort_word4", 32'h44332211, 1'b0, 2);
`else
        run_req(1'b0, F3_W, 32'h2, '0);
        check_rsp("lw2_err", 32'h0, 1'b1, 1);
        check_eq("lw2_err_mem", rd_n + wr_n, 0);
        run_req(1'b0, F3_H, 32'h3, '0);
        check_rsp("lh3_err", 32'h0, 1'b1, 1);
        run_req(1'b1, F3_W, 32'h1, 32'hAABBCCDD);
        check_rsp("sw1_err", 32'h0, 1'b1, 1);
        check_eq("sw1_err_wr_n", wr_n, 0);
        run_req(1'b0, F3_W, 32'h0, '0);
        check_rsp("word0_intact", 32'h88776655, 1'b0, 2);

        // Reset during an aligned load access
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h4;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        #2 check_eq("abort_rd_before", bus.mem_rd_en, 1);
        reset = 1'b1;
        #1 check_eq("abort_rd_en", bus.mem_rd_en, 0);
        check_eq("abort_mem_addr", bus.mem_addr, 0);
        check_eq("abort_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 check_eq("abort_req_ready", bus.req_ready, 1);
        run_req(1'b0, F3_W, 32'h4, '0);
        check_rsp("abort_word4", 32'h44332211, 1'b0, 2);
`endif

        check_eq("rd_wr_exclusive", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
